// File: rtl/morph_seq_ctrl_pkg.sv
// Shared constants, state encoding and the op -> engine pass plan for the
// morphology/histogram sequencer.
package morph_seq_ctrl_pkg;

    localparam int WORDS    = 256;
    localparam int ADDR_W   = 8;
    localparam int SE_WORDS = 16;

    localparam logic [2:0] OP_HIST   = 3'b000;
    localparam logic [2:0] OP_ERODE  = 3'b010;
    localparam logic [2:0] OP_DILATE = 3'b011;
    localparam logic [2:0] OP_OPEN   = 3'b110;
    localparam logic [2:0] OP_CLOSE  = 3'b111;

    localparam logic [1:0] MODE_ERODE    = 2'd0;
    localparam logic [1:0] MODE_DILATE   = 2'd1;
    localparam logic [1:0] MODE_HIST_ACC = 2'd2;
    localparam logic [1:0] MODE_HIST_MAP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PASS,
        ST_WAIT,
        ST_RD
    } state_t;

    // Returns {n_pass, mode0, mode1}; unlisted ops run no passes and echo the input.
    function automatic logic [5:0] pass_plan(input logic [2:0] op);
        case (op)
            OP_HIST:   pass_plan = {2'd2, MODE_HIST_ACC, MODE_HIST_MAP};
            OP_ERODE:  pass_plan = {2'd1, MODE_ERODE,    MODE_ERODE};
            OP_DILATE: pass_plan = {2'd1, MODE_DILATE,   MODE_DILATE};
            OP_OPEN:   pass_plan = {2'd2, MODE_ERODE,    MODE_DILATE};
            OP_CLOSE:  pass_plan = {2'd2, MODE_DILATE,   MODE_ERODE};
            default:   pass_plan = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/morph_seq_ctrl_beat_cnt.sv
// Beat/address counter shared by the image load and the result readout.
// Wraps to 0 after the terminal beat; clr forces it back to 0.
module morph_beat_cnt
    import morph_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              term_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == ADDR_W'(WORDS - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = term_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morph_seq_ctrl.sv
// Frame sequencer: image/SE load, 0-2 engine passes over ping-pong banks,
// then the 256-beat readout with out_valid aligned to SRAM read data.
module morph_seq_ctrl
    import morph_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              op_valid,
    input  logic [2:0]        op,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_bank,
    output logic              se_we,
    output logic [3:0]        se_idx,
    output logic              eng_start,
    output logic [1:0]        eng_mode,
    output logic              eng_src_bank,
    input  logic              eng_done,
    output logic              out_valid,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        pass_q, pass_d;
    logic              src_q, src_d;
    logic              ovld_q;

    logic              accept;
    logic              cnt_en, cnt_clr, cnt_term;
    logic [ADDR_W-1:0] cnt;
    logic [5:0]        plan_cur, plan_nxt;
    logic [1:0]        mode_cur;

    // A new frame is refused while the last readout beat is still in flight.
    assign accept   = in_valid && ((state_q == ST_IDLE && !ovld_q) || state_q == ST_LOAD);
    assign op_d     = (op_valid && (accept || state_q == ST_LOAD)) ? op : op_q;
    assign plan_cur = pass_plan(op_q);
    assign plan_nxt = pass_plan(op_d);
    assign mode_cur = (pass_q == 2'd0) ? plan_cur[3:2] : plan_cur[1:0];

    morph_beat_cnt u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (cnt_en),
        .clr_i  (cnt_clr),
        .cnt_o  (cnt),
        .term_o (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HIST;
            pass_q  <= 2'd0;
            src_q   <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pass_q  <= pass_d;
            src_q   <= src_d;
            ovld_q  <= mem_re;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        src_d   = src_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // The op strobed on the final beat already decides the plan.
                if (accept && cnt_term) begin
                    pass_d  = 2'd0;
                    src_d   = 1'b0;
                    state_d = (plan_nxt[5:4] == 2'd0) ? ST_RD : ST_PASS;
                end
            end
            ST_PASS: state_d = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    src_d   = ~src_q;
                    pass_d  = pass_q + 2'd1;
                    state_d = (pass_q + 2'd1 < plan_cur[5:4]) ? ST_PASS : ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_term) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we       = accept;
        mem_re       = (state_q == ST_RD);
        mem_addr     = '0;
        mem_bank     = 1'b0;
        se_we        = 1'b0;
        se_idx       = 4'd0;
        eng_start    = 1'b0;
        eng_mode     = 2'd0;
        eng_src_bank = 1'b0;
        if (mem_we || mem_re) mem_addr = cnt;
        if (mem_re) mem_bank = src_q;
        if (accept && cnt < ADDR_W'(SE_WORDS)) begin
            se_we  = 1'b1;
            se_idx = cnt[3:0];
        end
        if (state_q == ST_PASS || state_q == ST_WAIT) begin
            eng_start    = (state_q == ST_PASS);
            eng_mode     = mode_cur;
            eng_src_bank = src_q;
        end
        cnt_en    = accept || mem_re;
        cnt_clr   = (state_q == ST_IDLE) && !accept;
        busy      = (state_q != ST_IDLE);
        out_valid = ovld_q;
    end

endmodule
